gust_row_accumulator: RTL and testbench

- N-lane partial-sum accumulator for the GUST SpMV datapath. Sits after the per-lane multipliers and in place of the single-register adder stage.
- Each lane owns a bank of 2^index_size row partial sums. Incoming products are added into the row they address.
- A per-lane flush emits a finished row sum and clears that entry.
- Generalises the earlier adder stage in three ways: selectable FP32 or integer arithmetic, many live rows per lane, and an occupancy/empty status.

---
 rtl/gust_row_accumulator.sv | 154 +++++++++++++++
 tb/tb_gust_row_accumulator.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/gust_row_accumulator.sv
// N-lane row partial-sum accumulator for the GUST SpMV datapath.
// Each lane keeps a bank of row sums that are added into, flushed out and cleared independently.

module fp_adder (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] sum
);
  logic        a_big, sign_big, sub, round_up;
  logic        a_nan, b_nan, a_inf, b_inf;
  logic [7:0]  ea, eb, e_big, e_small, diff;
  logic [23:0] ma, mb, m_big, m_small;
  logic [26:0] big_ext, small_ext, norm;
  logic [49:0] shifted;
  logic [27:0] raw;
  logic [9:0]  exp_n;
  logic [4:0]  lz, shift;
  logic [24:0] rounded;

  // Guard/round/sticky add with round-to-nearest-even; denormals keep an effective exponent of 1.
  always_comb begin
    sum     = '0;
    norm    = '0;
    shift   = '0;
    lz      = '0;
    ea      = (a[30:23] == 8'd0) ? 8'd1 : a[30:23];
    eb      = (b[30:23] == 8'd0) ? 8'd1 : b[30:23];
    ma      = {a[30:23] != 8'd0, a[22:0]};
    mb      = {b[30:23] != 8'd0, b[22:0]};
    a_big   = {ea, ma} >= {eb, mb};
    e_big   = a_big ? ea : eb;
    e_small = a_big ? eb : ea;
    m_big   = a_big ? ma : mb;
    m_small = a_big ? mb : ma;
    sign_big = a_big ? a[31] : b[31];
    sub     = a[31] ^ b[31];
    diff    = e_big - e_small;
    shifted = {m_small, 26'd0} >> ((diff > 8'd26) ? 8'd26 : diff);
    big_ext   = {m_big, 3'b000};
    small_ext = {shifted[49:24], |shifted[23:0]};
    raw = sub ? ({1'b0, big_ext} - {1'b0, small_ext})
              : ({1'b0, big_ext} + {1'b0, small_ext});

    for (int i = 0; i < 27; i++) begin
      if (raw[i]) lz = 5'(26 - i);
    end

    exp_n = {2'b00, e_big};
    if (raw[27]) begin
      norm  = {raw[27:2], raw[1] | raw[0]};
      exp_n = exp_n + 10'd1;
    end else begin
      shift = (10'(lz) < exp_n) ? lz : 5'(exp_n - 10'd1);
      norm  = raw[26:0] << shift;
      exp_n = exp_n - 10'(shift);
    end

    round_up = norm[2] & (norm[1] | norm[0] | norm[3]);
    rounded  = {1'b0, norm[26:3]} + 25'(round_up);
    if (rounded[24]) begin
      rounded = rounded >> 1;
      exp_n   = exp_n + 10'd1;
    end

    a_nan = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
    b_nan = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
    a_inf = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
    b_inf = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);

    if (a_nan || b_nan || (a_inf && b_inf && sub))
      sum = 32'h7FC00000;
    else if (a_inf)
      sum = a;
    else if (b_inf)
      sum = b;
    else if (raw == 28'd0)
      sum = {a[31] & b[31], 31'd0};
    else if (exp_n >= 10'd255)
      sum = {sign_big, 8'hFF, 23'd0};
    else
      sum = {sign_big, rounded[23] ? exp_n[7:0] : 8'd0, rounded[22:0]};
  end
endmodule

module gust_row_accumulator #(
  parameter int N          = 2,
  parameter int value_size = 32,
  parameter int index_size = 3,
  parameter int ACC_MODE   = 0
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [N-1:0]                     in_valid,
  input  logic [N*value_size-1:0]          in_val,
  input  logic [N*index_size-1:0]          in_row,
  input  logic [N-1:0]                     flush,
  input  logic [N*index_size-1:0]          flush_row,
  output logic [N*value_size-1:0]          ans,
  output logic [N*index_size-1:0]          ans_row,
  output logic [N-1:0]                     ready,
  output logic [N*(2**index_size)-1:0]     live,
  output logic [N-1:0]                     empty
);
  localparam int DEPTH = 2 ** index_size;

  for (genvar l = 0; l < N; l++) begin : g_lane
    logic [value_size-1:0] psum [DEPTH];
    logic [DEPTH-1:0]      live_q;
    logic [value_size-1:0] ans_q, val, cur_sum, acc_out;
    logic [index_size-1:0] ans_row_q, row, frow;
    logic                  ready_q, same_row;

    assign val      = in_val[l*value_size +: value_size];
    assign row      = in_row[l*index_size +: index_size];
    assign frow     = flush_row[l*index_size +: index_size];
    assign cur_sum  = psum[row];
    assign same_row = in_valid[l] && flush[l] && (row == frow);

    if (ACC_MODE == 0) begin : g_fp
      fp_adder u_add (.a(cur_sum), .b(val), .sum(acc_out));
    end else begin : g_int
      assign acc_out = cur_sum + val;
    end

    // A same-row flush folds the in-flight product into the emitted sum and still clears the entry.
    always_ff @(posedge clk) begin
      if (rst) begin
        for (int r = 0; r < DEPTH; r++) psum[r] <= '0;
        live_q    <= '0;
        ready_q   <= 1'b0;
        ans_q     <= '0;
        ans_row_q <= '0;
      end else begin
        ready_q <= flush[l];
        if (in_valid[l] && !same_row) begin
          psum[row]   <= acc_out;
          live_q[row] <= 1'b1;
        end
        if (flush[l]) begin
          ans_q        <= same_row ? acc_out : psum[frow];
          ans_row_q    <= frow;
          psum[frow]   <= '0;
          live_q[frow] <= 1'b0;
        end
      end
    end

    assign ans[l*value_size +: value_size]     = ans_q;
    assign ans_row[l*index_size +: index_size] = ans_row_q;
    assign ready[l]                            = ready_q;
    assign live[l*DEPTH +: DEPTH]              = live_q;
    assign empty[l]                            = ~|live_q;
  end
endmodule

// File: tb/tb_gust_row_accumulator.sv
// Bench for gust_row_accumulator: an FP32 and an integer instance share stimulus;
// a row-level reference model predicts status for both and sums for the integer one.

module tb_gust_row_accumulator;
  localparam int N     = 2;
  localparam int VW    = 32;
  localparam int IW    = 3;
  localparam int DEPTH = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic [N-1:0]      in_valid, flush;
  logic [N*VW-1:0]   in_val;
  logic [N*IW-1:0]   in_row, flush_row;
  logic [N*VW-1:0]   ans_f, ans_i;
  logic [N*IW-1:0]   ans_row_f, ans_row_i;
  logic [N-1:0]      ready_f, ready_i, empty_f, empty_i;
  logic [N*DEPTH-1:0] live_f, live_i;

  int tests = 0;
  int fails = 0;

  logic [31:0] m_sum [N][DEPTH];
  logic        m_live [N][DEPTH];
  logic [31:0] m_ans [N];
  logic [2:0]  m_ans_row [N];
  logic        m_ready [N];

  always #5 clk = ~clk;

  gust_row_accumulator #(.N(N), .value_size(VW), .index_size(IW), .ACC_MODE(0)) dut_fp (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_val(in_val), .in_row(in_row),
    .flush(flush), .flush_row(flush_row), .ans(ans_f), .ans_row(ans_row_f),
    .ready(ready_f), .live(live_f), .empty(empty_f)
  );

  gust_row_accumulator #(.N(N), .value_size(VW), .index_size(IW), .ACC_MODE(1)) dut_int (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_val(in_val), .in_row(in_row),
    .flush(flush), .flush_row(flush_row), .ans(ans_i), .ans_row(ans_row_i),
    .ready(ready_i), .live(live_i), .empty(empty_i)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $display("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
      $error("[TB] %s check did not hold", tag);
    end
  endtask

  task automatic modelReset();
    for (int l = 0; l < N; l++) begin
      for (int r = 0; r < DEPTH; r++) begin
        m_sum[l][r]  = '0;
        m_live[l][r] = 1'b0;
      end
      m_ans[l]     = '0;
      m_ans_row[l] = '0;
      m_ready[l]   = 1'b0;
    end
  endtask

  // Status is arithmetic-independent, so both instances are held to it; sums only for the integer one.
  task automatic checkAll(input string tag);
    logic [N*DEPTH-1:0] exp_live;
    logic [N-1:0]       exp_empty, exp_ready;
    logic [N*VW-1:0]    exp_ans;
    logic [N*IW-1:0]    exp_row;
    for (int l = 0; l < N; l++) begin
      exp_ready[l]           = m_ready[l];
      exp_ans[l*VW +: VW]    = m_ans[l];
      exp_row[l*IW +: IW]    = m_ans_row[l];
      exp_empty[l]           = 1'b1;
      for (int r = 0; r < DEPTH; r++) begin
        exp_live[l*DEPTH + r] = m_live[l][r];
        if (m_live[l][r]) exp_empty[l] = 1'b0;
      end
    end
    checkOutput($sformatf("%s.int_ready", tag), 64'(ready_i), 64'(exp_ready));
    checkOutput($sformatf("%s.int_ans", tag), 64'(ans_i), 64'(exp_ans));
    checkOutput($sformatf("%s.int_ans_row", tag), 64'(ans_row_i), 64'(exp_row));
    checkOutput($sformatf("%s.int_live", tag), 64'(live_i), 64'(exp_live));
    checkOutput($sformatf("%s.int_empty", tag), 64'(empty_i), 64'(exp_empty));
    checkOutput($sformatf("%s.fp_ready", tag), 64'(ready_f), 64'(exp_ready));
    checkOutput($sformatf("%s.fp_ans_row", tag), 64'(ans_row_f), 64'(exp_row));
    checkOutput($sformatf("%s.fp_live", tag), 64'(live_f), 64'(exp_live));
    checkOutput($sformatf("%s.fp_empty", tag), 64'(empty_f), 64'(exp_empty));
  endtask

  task automatic applyStimulus(input string tag, input logic [1:0] v,
                               input logic [31:0] val0, input logic [31:0] val1,
                               input logic [2:0] r0, input logic [2:0] r1,
                               input logic [1:0] f, input logic [2:0] fr0, input logic [2:0] fr1);
    logic [31:0] vals [N];
    logic [2:0]  rows [N];
    logic [2:0]  frows [N];
    vals[0] = val0;  vals[1] = val1;
    rows[0] = r0;    rows[1] = r1;
    frows[0] = fr0;  frows[1] = fr1;
    in_valid  = v;
    flush     = f;
    in_val    = {val1, val0};
    in_row    = {r1, r0};
    flush_row = {fr1, fr0};
    for (int l = 0; l < N; l++) begin
      m_ready[l] = f[l];
      if (f[l]) begin
        m_ans[l]     = m_sum[l][frows[l]] + ((v[l] && rows[l] == frows[l]) ? vals[l] : 32'd0);
        m_ans_row[l] = frows[l];
      end
      if (v[l]) begin
        m_sum[l][rows[l]]  = m_sum[l][rows[l]] + vals[l];
        m_live[l][rows[l]] = 1'b1;
      end
      if (f[l]) begin
        m_sum[l][frows[l]]  = '0;
        m_live[l][frows[l]] = 1'b0;
      end
    end
    tick();
    in_valid = '0;
    flush    = '0;
    checkAll(tag);
  endtask

  task automatic doReset(input string tag, input logic [1:0] f, input logic [2:0] fr0, input logic [2:0] fr1);
    in_valid  = '0;
    flush     = f;
    flush_row = {fr1, fr0};
    rst       = 1'b1;
    tick();
    rst   = 1'b0;
    flush = '0;
    modelReset();
    checkAll(tag);
  endtask

  initial begin
    rst = 1'b1; in_valid = '0; flush = '0; in_val = '0; in_row = '0; flush_row = '0;
    modelReset();

    doReset("reset", 2'b00, 3'd0, 3'd0);
    for (int i = 0; i < 3; i++) applyStimulus("idle", 2'b00, 0, 0, 0, 0, 2'b00, 0, 0);
    checkOutput("reset.fp_ans", 64'(ans_f), 64'd0);

    applyStimulus("fp_a", 2'b01, 32'h3F8CCCCD, 0, 3'd1, 0, 2'b00, 0, 0);
    applyStimulus("fp_b", 2'b01, 32'h40066666, 0, 3'd1, 0, 2'b00, 0, 0);
    applyStimulus("fp_flush", 2'b00, 0, 0, 0, 0, 2'b01, 3'd1, 0);
    checkOutput("fp_flush.sum", 64'(ans_f[31:0]), 64'(32'h404CCCCC));
    checkOutput("fp_flush.row", 64'(ans_row_f[2:0]), 64'(3'd1));
    applyStimulus("fp_after", 2'b00, 0, 0, 0, 0, 2'b00, 0, 0);
    checkOutput("fp_after.live01", 64'(live_f[1]), 64'(1'b0));
    checkOutput("fp_after.empty0", 64'(empty_f[0]), 64'(1'b1));

    applyStimulus("fp_c", 2'b11, 32'h3FC00000, 32'h3F800000, 3'd7, 3'd6, 2'b00, 0, 0);
    applyStimulus("fp_d", 2'b11, 32'hBFC00000, 32'h40000000, 3'd7, 3'd6, 2'b00, 0, 0);
    applyStimulus("fp_e", 2'b00, 0, 0, 0, 0, 2'b11, 3'd7, 3'd6);
    checkOutput("fp_cancel.sum", 64'(ans_f[31:0]), 64'(32'h00000000));
    checkOutput("fp_three.sum", 64'(ans_f[63:32]), 64'(32'h40400000));
    applyStimulus("fp_f", 2'b10, 0, 32'h3F800000, 0, 3'd2, 2'b00, 0, 0);
    applyStimulus("fp_g", 2'b10, 0, 32'h3F800000, 0, 3'd2, 2'b10, 0, 3'd2);
    checkOutput("fp_same_row.sum", 64'(ans_f[63:32]), 64'(32'h40000000));

    applyStimulus("int3_a", 2'b10, 0, 32'd7, 0, 3'd3, 2'b00, 0, 0);
    applyStimulus("int3_b", 2'b10, 0, 32'd5, 0, 3'd3, 2'b10, 0, 3'd3);
    checkOutput("int3.sum", 64'(ans_i[63:32]), 64'(32'd12));
    checkOutput("int3.row", 64'(ans_row_i[5:3]), 64'(3'd3));
    applyStimulus("int3_c", 2'b00, 0, 0, 0, 0, 2'b00, 0, 0);
    checkOutput("int3.live13", 64'(live_i[DEPTH + 3]), 64'(1'b0));

    applyStimulus("wrap_a", 2'b01, 32'hFFFFFFFF, 0, 3'd0, 0, 2'b00, 0, 0);
    applyStimulus("wrap_b", 2'b01, 32'd2, 0, 3'd0, 0, 2'b00, 0, 0);
    applyStimulus("wrap_c", 2'b00, 0, 0, 0, 0, 2'b01, 3'd0, 0);
    checkOutput("wrap.sum", 64'(ans_i[31:0]), 64'(32'd1));

    applyStimulus("indep_a", 2'b01, 32'd9, 0, 3'd5, 0, 2'b00, 0, 0);
    applyStimulus("indep_b", 2'b01, 32'd4, 0, 3'd2, 0, 2'b01, 3'd5, 0);
    checkOutput("indep.sum", 64'(ans_i[31:0]), 64'(32'd9));
    checkOutput("indep.row", 64'(ans_row_i[2:0]), 64'(3'd5));
    checkOutput("indep.live02", 64'(live_i[2]), 64'(1'b1));
    checkOutput("indep.lane1_hold", 64'(ans_i[63:32]), 64'(32'd12));
    checkOutput("indep.lane1_ready", 64'(ready_i[1]), 64'(1'b0));

    applyStimulus("rst_a", 2'b01, 32'd3, 0, 3'd0, 0, 2'b00, 0, 0);
    applyStimulus("rst_b", 2'b01, 32'd8, 0, 3'd4, 0, 2'b00, 0, 0);
    doReset("rst_mid", 2'b01, 3'd4, 0);
    checkOutput("rst_mid.ready", 64'(ready_i), 64'(2'b00));
    checkOutput("rst_mid.live", 64'(live_i), 64'd0);
    applyStimulus("rst_flush", 2'b00, 0, 0, 0, 0, 2'b01, 3'd4, 0);
    checkOutput("rst_flush.int_sum", 64'(ans_i[31:0]), 64'd0);
    checkOutput("rst_flush.fp_sum", 64'(ans_f[31:0]), 64'd0);

    for (int i = 0; i < 300; i++) begin
      applyStimulus("random", 2'($urandom_range(0, 3)), $urandom, $urandom,
                    3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                    {($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0)},
                    3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
      if (i == 150) doReset("random_rst", 2'b11, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
